// File: rtl/spi_master_tx.sv
// spi_master_tx
//   Serial transmit stage of the SPI link. Takes one DATA_WIDTH-bit word over a
//   valid/ready handshake and shifts it out MSB-first in SPI mode 0 (CPOL=0,
//   CPHA=0), framed by an active-low chip select.
//
// Ports
//   clock     system clock, all state on rising edge
//   reset     asynchronous, active-low reset
//   tx_data   word to send, sampled only on the accepting edge
//   tx_valid  upstream has a word
//   tx_ready  block can accept (state == IDLE)
//   mosi      serial data, MSB first, changes on falling sclk
//   sclk      serial clock, idles low, half-period = CLK_DIV clocks
//   cs_n      frame select, active low
//   busy      frame in progress (state != IDLE)
//   done      one-cycle pulse in the cycle cs_n returns high
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cs_n high, waiting for tx_valid
// SETUP | cs_n low, first bit on mosi, waiting CLK_DIV before first rise
// HIGH  | sclk high, receiver samples mosi
// LOW   | sclk low, next bit already on mosi
// HOLD  | last bit sent, cs_n kept low CLK_DIV cycles before release

module spi_master_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  mosi,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } state_t;

  state_t                  state, state_nxt;
  logic [DIV_W-1:0]        div_cnt, div_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_nxt;
  logic                    mosi_nxt, sclk_nxt, cs_n_nxt, done_nxt;
  logic                    div_end;
  logic [BIT_W-1:0]        bit_inc;

  assign div_end  = (div_cnt == DIV_LAST);
  assign bit_inc  = bit_cnt + 1'b1;
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      mosi      <= 1'b0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      mosi      <= mosi_nxt;
      sclk      <= sclk_nxt;
      cs_n      <= cs_n_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    mosi_nxt  = mosi;
    sclk_nxt  = sclk;
    cs_n_nxt  = cs_n;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_nxt = tx_data;
          mosi_nxt  = tx_data[DATA_WIDTH-1];
          cs_n_nxt  = 1'b0;
          div_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = SETUP;
        end
      end

      SETUP, LOW: begin
        if (div_end) begin
          div_nxt   = '0;
          sclk_nxt  = 1'b1;
          state_nxt = HIGH;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      HIGH: begin
        if (div_end) begin
          div_nxt  = '0;
          bit_nxt  = bit_inc;
          sclk_nxt = 1'b0;
          if (bit_inc < BIT_ALL) begin
            // Rotate rather than shift: the bit leaving the top is never
            // looked at again, and rotating keeps every register bit in use.
            shift_nxt = {shift_reg[DATA_WIDTH-2:0], shift_reg[DATA_WIDTH-1]};
            mosi_nxt  = shift_reg[DATA_WIDTH-2];
            state_nxt = LOW;
          end else begin
            state_nxt = HOLD;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      HOLD: begin
        if (div_end) begin
          div_nxt   = '0;
          cs_n_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Testbench for spi_master_tx. Two instances (CLK_DIV=2 and CLK_DIV=1) share
// clock, reset and tx_data; sel routes tx_valid to one and picks which one
// is observed.

module tb_spi_master_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       sel;

  logic d2_valid, d2_ready, d2_mosi, d2_sclk, d2_cs_n, d2_busy, d2_done;
  logic d1_valid, d1_ready, d1_mosi, d1_sclk, d1_cs_n, d1_busy, d1_done;
  logic mon_ready, mon_mosi, mon_sclk, mon_cs_n, mon_busy, mon_done;

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int done_total = 0;

  always #5 clock = ~clock;

  assign d2_valid = tx_valid & ~sel;
  assign d1_valid = tx_valid & sel;

  spi_master_tx #(.DATA_WIDTH(8), .CLK_DIV(2)) u_div2 (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(d2_valid),
    .tx_ready(d2_ready), .mosi(d2_mosi), .sclk(d2_sclk), .cs_n(d2_cs_n),
    .busy(d2_busy), .done(d2_done)
  );

  spi_master_tx #(.DATA_WIDTH(8), .CLK_DIV(1)) u_div1 (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(d1_valid),
    .tx_ready(d1_ready), .mosi(d1_mosi), .sclk(d1_sclk), .cs_n(d1_cs_n),
    .busy(d1_busy), .done(d1_done)
  );

  assign mon_ready = sel ? d1_ready : d2_ready;
  assign mon_mosi  = sel ? d1_mosi  : d2_mosi;
  assign mon_sclk  = sel ? d1_sclk  : d2_sclk;
  assign mon_cs_n  = sel ? d1_cs_n  : d2_cs_n;
  assign mon_busy  = sel ? d1_busy  : d2_busy;
  assign mon_done  = sel ? d1_done  : d2_done;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (mon_done) done_total = done_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call right after the accepting rising edge. Samples every negedge,
  // models the downstream SIPO (shift mosi on each sclk rise) and checks the
  // frame against the mode-0 timing for the given CLK_DIV.
  task automatic watch_frame(input string tag, input logic [7:0] exp_data, input int cd,
                             input bit drop_valid, input bit interfere, input bit swap_data,
                             output int done_abs, output int hi_min, output int hi_max);
    logic [7:0] sipo = 8'h00;
    int   rises = 0, cs_low = 0, done_cyc = -1, t_err = 0, m_err = 0, hi_run = 0;
    logic p_sclk = 1'b0, p_mosi = 1'b0;
    logic busy0 = 1'b0, ready0 = 1'b1, rdy_done = 1'b0, cs_done = 1'b0;
    bit   seen = 1'b0;
    hi_min   = 1000;
    hi_max   = 0;
    done_abs = -1;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clock);
      if (c == 0 && drop_valid) tx_valid = 1'b0;
      if (swap_data && c == 1) tx_data = 8'hC3;
      if (interfere && c == 10) begin tx_data = 8'h7E; tx_valid = 1'b1; end
      if (interfere && c == 12) tx_valid = 1'b0;
      if (c == 0) begin busy0 = mon_busy; ready0 = mon_ready; end
      if (mon_sclk && !p_sclk) begin
        rises++;
        sipo = {sipo[6:0], mon_mosi};
        if (c != cd * (2 * rises - 1)) t_err++;
      end
      if (!mon_sclk && p_sclk) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      if (mon_sclk) hi_run++;
      if (!mon_cs_n) cs_low++;
      if (mon_mosi !== p_mosi && c != 0 && !mon_done && !(p_sclk && !mon_sclk)) m_err++;
      if (mon_done) begin
        seen     = 1'b1;
        done_cyc = c;
        done_abs = cyc;
        rdy_done = mon_ready;
        cs_done  = mon_cs_n;
      end
      p_sclk = mon_sclk;
      p_mosi = mon_mosi;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_c0"}, {busy0, ready0}, 2'b10);
    check({tag, "_bits"}, sipo, exp_data);
    check({tag, "_rises"}, rises, 8);
    check({tag, "_rise_timing"}, t_err, 0);
    check({tag, "_mosi_stable"}, m_err, 0);
    check({tag, "_cs_low_len"}, cs_low, 17 * cd);
    check({tag, "_done_cycle"}, done_cyc, 17 * cd);
    check({tag, "_done_cs_ready"}, {cs_done, rdy_done}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d_a, d_b, hmin, hmax, bad, r, dt;
    logic p;
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    sel      = 1'b0;

    repeat (3) @(negedge clock);
    check("reset_outs", {mon_cs_n, mon_sclk, mon_mosi, mon_done, mon_busy, mon_ready}, 6'b100001);
    reset = 1'b1;

    // Idle hold
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (mon_sclk || !mon_cs_n || !mon_ready || d1_sclk || !d1_cs_n) bad++;
    end
    check("idle_hold", bad, 0);

    // Single frame, CLK_DIV=2, 0xA5
    @(negedge clock);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clock);
    watch_frame("t1", 8'hA5, 2, 1'b1, 1'b0, 1'b0, d_a, hmin, hmax);
    check("t1_hi_width", {hmin[7:0], hmax[7:0]}, 16'h0202);

    // Back-to-back, CLK_DIV=1, 0x3C then 0xC3 with tx_valid held
    @(negedge clock);
    sel = 1'b1; tx_data = 8'h3C; tx_valid = 1'b1;
    @(posedge clock);
    watch_frame("t2a", 8'h3C, 1, 1'b0, 1'b0, 1'b1, d_a, hmin, hmax);
    watch_frame("t2b", 8'hC3, 1, 1'b1, 1'b0, 1'b0, d_b, hmin, hmax);
    check("t2_done_gap", d_b - d_a, 18);

    // Mid-frame interference, CLK_DIV=2, 0x81
    @(negedge clock);
    sel = 1'b0; tx_data = 8'h81; tx_valid = 1'b1;
    @(posedge clock);
    watch_frame("t3", 8'h81, 2, 1'b1, 1'b1, 1'b0, d_a, hmin, hmax);
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (!mon_cs_n || mon_busy) bad++;
    end
    check("t3_no_second_frame", bad, 0);

    // Reset after the 3rd sclk rise of 0xF0
    @(negedge clock);
    tx_data = 8'hF0; tx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    tx_valid = 1'b0;
    r = 0; p = mon_sclk;
    for (int i = 0; i < 100 && r < 3; i++) begin
      @(negedge clock);
      if (mon_sclk && !p) r++;
      p = mon_sclk;
    end
    check("t4_rises_before_reset", r, 3);
    dt = done_total;
    reset = 1'b0;
    #1;
    check("t4_reset_outs", {mon_cs_n, mon_sclk, mon_mosi, mon_busy, mon_done, mon_ready}, 6'b100001);
    repeat (3) @(negedge clock);
    check("t4_no_done", done_total - dt, 0);
    reset = 1'b1;
    @(negedge clock);
    tx_data = 8'h55; tx_valid = 1'b1;
    @(posedge clock);
    watch_frame("t4b", 8'h55, 2, 1'b1, 1'b0, 1'b0, d_a, hmin, hmax);

    // Boundary data, CLK_DIV=1
    @(negedge clock);
    sel = 1'b1; tx_data = 8'hFF; tx_valid = 1'b1;
    @(posedge clock);
    watch_frame("t5ff", 8'hFF, 1, 1'b1, 1'b0, 1'b0, d_a, hmin, hmax);
    check("t5ff_hi_width", {hmin[7:0], hmax[7:0]}, 16'h0101);
    @(negedge clock);
    tx_data = 8'h00; tx_valid = 1'b1;
    @(posedge clock);
    watch_frame("t500", 8'h00, 1, 1'b1, 1'b0, 1'b0, d_a, hmin, hmax);
    check("t500_hi_width", {hmin[7:0], hmax[7:0]}, 16'h0101);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
